note_lane_renderer: RTL and testbench
=====================================

// Module: note_lane_renderer
// PURPOSE
// Consumer side of the per-lane note double buffer: takes the 8-bit note y-position
// the buffer delivers once per frame and turns it into pixel writes for the VGA adapter.
// Erases the lane's previous note rectangle, then draws the new one.
// One instance per lane; outputs are muxed/arbitrated into the VGA adapter plot port.
// PARAMETERS
// LANE_X     8'd72   left x of the lane's note rectangle (160x120 screen)
// NOTE_W     16      note width in pixels (1..32)
// NOTE_H     4       note height in pixels (1..16)
// SCREEN_H   120     visible rows; any row >= SCREEN_H is clipped
// NOTE_COL   3'b110  draw colour
// BG_COL     3'b000  erase colour
// PORTS
// clk         in   1  system clock (same domain as the frame buffer read side)
// resetn      in   1  asynchronous, active-low reset
// start       in   1  1-cycle frame strobe; y_in is valid in the same cycle
// y_in        in   8  note top row for this frame (from the double buffer's oy)
// plot_ready  in   1  VGA adapter accepts the current pixel this cycle
// x           out  8  pixel x
// y           out  7  pixel y
// colour      out  3  pixel colour
// plot        out  1  pixel write request
// busy        out  1  frame update in progress
// done        out  1  1-cycle pulse when the frame update completes
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0;
//   have_prev=0, prev_y=0, cx=cy=0.
// - States: IDLE -> ERASE -> DRAW -> FIN -> IDLE. All outputs registered.
// - IDLE: a start accepted while busy=0 latches new_y=y_in and clears cx,cy.
//   Goes to ERASE if have_prev=1, else straight to DRAW. busy=1 from the next cycle.
// - start while busy=1 is ignored; the latched new_y is unchanged.
// - Scan order: raster scan, cx 0..NOTE_W-1 inner, cy 0..NOTE_H-1 outer.
//   Pixel x = LANE_X+cx (8-bit, wraps mod 256).
//   Pixel row = base+cy, computed in 9 bits; base=prev_y in ERASE, new_y in DRAW.
// - Pixel handshake:
//   - If row < SCREEN_H: present x, y=row[6:0], colour (BG_COL in ERASE, NOTE_COL in DRAW),
//     and plot=1.
//   - x/y/colour are held stable while plot=1 and plot_ready=0.
//   - The scan advances only on a cycle with plot=1 and plot_ready=1.
//   - If row >= SCREEN_H: plot=0 and the scan advances unconditionally, 1 cycle per clipped pixel.
// - The last pixel of ERASE (cx=NOTE_W-1, cy=NOTE_H-1) advances to DRAW with cx,cy cleared.
// - The last pixel of DRAW advances to FIN.
// - FIN (one cycle): done=1, prev_y<=new_y, have_prev<=1, plot=0; then IDLE with busy=0.
// - Latency with plot_ready tied high:
//   - 1 (accept) + W*H (erase, if have_prev) + W*H (draw) + 1 (FIN) cycles from start to done.
//   - With defaults, the first frame takes 66 cycles and later frames take 130.
// - y_in >= SCREEN_H is a hidden note: every pixel clips and no plot is issued; the full
//   cycle count is still spent and prev_y is still updated.
// - Reset mid-frame aborts immediately: plot drops, have_prev=0, and the next frame does
//   not erase.
// CONFIGURATION
// NOTE_SKIP_UNCHANGED_EN
// - Defined: a start with have_prev=1 and y_in==prev_y skips ERASE and DRAW.
//   - Accept goes straight to FIN: done pulses 2 cycles after start and no plot is issued.
// - Undefined: every accepted start performs the full erase+draw sequence.
// TESTING
// T1 reset, then start y_in=10 with plot_ready=1 -> 64 plots, all NOTE_COL, rows 10..13,
//    x 72..87; done at cycle 66; no BG_COL pixel.
// T2 after T1, start y_in=12 -> 64 BG_COL plots rows 10..13, then 64 NOTE_COL plots
//    rows 12..15; done at cycle 130.
// T3 start y_in=118 -> rows 118,119 plotted (32 pixels); rows 120,121 clipped;
//    done timing unchanged.
// T4 plot_ready toggled with a random 50% duty -> each pixel is plotted exactly once,
//    x/y/colour are stable while stalled, and the pixel order is raster.
// T5 start during busy, then resetn=0 mid-DRAW -> second start ignored; all outputs
//    are 0 during reset; the next start does no erase.
// T6 NOTE_SKIP_UNCHANGED_EN: repeat y_in=12 -> zero plots and done 2 cycles after start.
//    Same stimulus without the macro -> 128 plots.

Source files
------------

// File: rtl/note_lane_renderer.sv
// Per-lane note renderer: erases the previous note rectangle and draws the new one as
// registered pixel writes. Optional macro NOTE_SKIP_UNCHANGED_EN skips frames whose y is unchanged.
module note_lane_renderer #(
  parameter logic [7:0] LANE_X   = 8'd72,
  parameter int         NOTE_W   = 16,
  parameter int         NOTE_H   = 4,
  parameter int         SCREEN_H = 120,
  parameter logic [2:0] NOTE_COL = 3'b110,
  parameter logic [2:0] BG_COL   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] y_in,
  input  logic       plot_ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ERASE = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [4:0] CX_LAST = 5'(NOTE_W - 1);
  localparam logic [3:0] CY_LAST = 4'(NOTE_H - 1);
  localparam logic [8:0] ROW_LIM = 9'(SCREEN_H);

  logic [1:0] state, n_state;
  logic [4:0] cx, n_cx;
  logic [3:0] cy, n_cy;
  logic [7:0] new_y, prev_y, base;
  logic       have_prev;
  logic       accept, skip, last, adv, load, vis;
  logic [8:0] row;
  logic [7:0] n_x;
  logic [2:0] n_colour;

  assign accept = (state == IDLE) && start && !busy;
`ifdef NOTE_SKIP_UNCHANGED_EN
  assign skip = have_prev && (y_in == prev_y);
`else
  assign skip = 1'b0;
`endif
  assign last = (cx == CX_LAST) && (cy == CY_LAST);
  // A clipped pixel has plot=0, so it advances without waiting for the adapter.
  assign adv  = ((state == ERASE) || (state == DRAW)) && (!plot || plot_ready);

  always_comb begin
    n_state = state;
    n_cx    = cx;
    n_cy    = cy;
    load    = 1'b0;
    if (accept) begin
      load    = 1'b1;
      n_cx    = '0;
      n_cy    = '0;
      n_state = skip ? FIN : (have_prev ? ERASE : DRAW);
    end else if (adv) begin
      load = 1'b1;
      if (!last) begin
        if (cx == CX_LAST) begin
          n_cx = '0;
          n_cy = cy + 4'd1;
        end else begin
          n_cx = cx + 5'd1;
        end
      end else begin
        n_cx    = '0;
        n_cy    = '0;
        n_state = (state == ERASE) ? DRAW : FIN;
      end
    end
  end

  // Outputs are computed for the pixel about to become current, so they can be registered.
  always_comb begin
    base     = (n_state == ERASE) ? prev_y : (accept ? y_in : new_y);
    row      = {1'b0, base} + {5'b0, n_cy};
    vis      = (row < ROW_LIM) && ((n_state == ERASE) || (n_state == DRAW));
    n_x      = LANE_X + {3'b0, n_cx};
    n_colour = (n_state == ERASE) ? BG_COL : NOTE_COL;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      new_y     <= '0;
      prev_y    <= '0;
      have_prev <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= load && (n_state == FIN);
      if (load) begin
        state <= n_state;
        cx    <= n_cx;
        cy    <= n_cy;
        plot  <= vis;
        if (vis) begin
          x      <= n_x;
          y      <= row[6:0];
          colour <= n_colour;
        end
      end
      if (accept) begin
        new_y <= y_in;
        busy  <= 1'b1;
      end
      if (state == FIN) begin
        state     <= IDLE;
        busy      <= 1'b0;
        plot      <= 1'b0;
        prev_y    <= new_y;
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Directed bench for note_lane_renderer: scoreboard of expected pixels, latency and reset checks.
module tb_note_lane_renderer;
  logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, plot_ready = 1'b0;
  logic [7:0] y_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  note_lane_renderer dut (
    .clk(clk), .resetn(resetn), .start(start), .y_in(y_in), .plot_ready(plot_ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [17:0] exp_q[$];
  bit          m_have = 1'b0;
  logic [7:0]  m_prev = '0;
  bit          ab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_rect(input logic [7:0] b, input logic [2:0] col);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        if (int'(b) + r < 120) exp_q.push_back({8'(72 + c), 7'(int'(b) + r), col});
  endtask

  task automatic model_frame(input logic [7:0] yv, output int lat);
    bit sk = 1'b0;
`ifdef NOTE_SKIP_UNCHANGED_EN
    sk = m_have && (yv == m_prev);
`endif
    if (sk) lat = 2;
    else begin
      if (m_have) push_rect(m_prev, 3'b000);
      push_rect(yv, 3'b110);
      lat = m_have ? 130 : 66;
    end
    m_have = 1'b1;
    m_prev = yv;
  endtask

  task automatic run_frame(input logic [7:0] yv, input bit rnd, input int inj_at,
                           input int abort_at, output bit aborted);
    int lat_exp, cyc;
    logic [17:0] e, held;
    bit stall;
    model_frame(yv, lat_exp);
    @(negedge clk);
    start = 1'b1; y_in = yv; plot_ready = 1'b1;
    stall = 1'b0; aborted = 1'b0; held = '0;
    for (cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == inj_at) begin start = 1'b1; y_in = 8'd99; end
      if (cyc == abort_at) begin aborted = 1'b1; break; end
      if (stall) chk("stall_hold", {13'b0, plot, x, y, colour}, {13'b0, 1'b1, held});
      plot_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (plot && plot_ready) begin
        e = (exp_q.size() == 0) ? '1 : exp_q.pop_front();
        chk("pixel", {14'b0, x, y, colour}, {14'b0, e});
      end
      stall = plot && !plot_ready;
      held  = {x, y, colour};
      if (done) break;
    end
    if (!aborted) begin
      if (!rnd) chk("latency", cyc + 1, lat_exp);
      else      chk("done_seen", {31'b0, cyc <= 2000}, 32'd1);
      chk("all_plotted", exp_q.size(), 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, {24'b0, x}, 0);
    chk({tag, "_y"}, {25'b0, y}, 0);
    chk({tag, "_colour"}, {29'b0, colour}, 0);
    chk({tag, "_plot"}, {31'b0, plot}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    resetn = 1'b1;
    run_frame(8'd10, 1'b0, -1, -1, ab);   // first frame: draw only
    run_frame(8'd12, 1'b0, -1, -1, ab);   // erase 10..13, draw 12..15
    run_frame(8'd118, 1'b0, -1, -1, ab);  // bottom rows clipped
    run_frame(8'd30, 1'b1, -1, -1, ab);   // random back-pressure
    run_frame(8'd60, 1'b1, -1, -1, ab);
    run_frame(8'd60, 1'b0, -1, -1, ab);   // unchanged y
    run_frame(8'd200, 1'b0, -1, -1, ab);  // hidden note
    run_frame(8'd5, 1'b0, -1, -1, ab);    // erase of hidden note clips entirely
    run_frame(8'd20, 1'b0, 10, 100, ab);  // start while busy, then abort mid-draw
    chk("aborted", {31'b0, ab}, 1);
    resetn = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_hold");
    resetn = 1'b1;
    exp_q.delete();
    m_have = 1'b0;
    run_frame(8'd50, 1'b0, -1, -1, ab);   // no erase after reset
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
